// File: rtl/mips_avalon_master_if.sv
// rtl/mips_avalon_master_if.sv - Avalon-MM master/slave bus bundle for mips_avalon_master
//
// Purpose: groups the Avalon-MM signals between the CPU-side master and a memory slave.
// Signals:
//   address     word-aligned byte address (master -> slave)
//   read/write  transfer strobes, never both high (master -> slave)
//   writedata   lane-replicated store data (master -> slave)
//   byteenable  active byte lanes (master -> slave)
//   waitrequest slave stall (slave -> master)
//   readdata    load data, valid on the completing edge (slave -> master)
interface mips_avalon_master_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_avalon_master.sv
// rtl/mips_avalon_master.sv - MIPS load/store to Avalon-MM master bridge
//
// Purpose: accepts one CPU load/store at a time, checks alignment, runs a single
// Avalon-MM transfer with byte lanes derived from size/offset, and returns an
// extended load result or an error strobe. All outputs are registered.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      CPU request handshake (ready only in IDLE)
//   req_write, req_addr,
//   req_size, req_signed,
//   req_wdata                request attributes, sampled only on acceptance
//   resp_valid               one-cycle completion strobe
//   resp_rdata, resp_err     result and error flag, held until the next response
//   av                       Avalon-MM master side of the bus bundle
// Parameter:
//   TIMEOUT                  stalled BUS cycles allowed before abort; 0 disables
module mips_avalon_master #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  mips_avalon_master_if.master av
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state, state_n;
  logic        lat_write, lat_write_n;
  logic [1:0]  lat_size, lat_size_n;
  logic        lat_signed, lat_signed_n;
  logic [1:0]  lat_off, lat_off_n;
  logic [31:0] wait_cnt, wait_cnt_n;

  logic        req_ready_n, resp_valid_n, resp_err_n;
  logic [31:0] resp_rdata_n;
  logic [31:0] address_n, writedata_n;
  logic        read_n, write_n;
  logic [3:0]  byteenable_n;

  logic        misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wd;

  // Shift the addressed lane down to bit 0, then truncate and extend by size.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   extend_load = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
      2'b01:   extend_load = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
      default: extend_load = sh;
    endcase
  endfunction

  always_comb begin
    misaligned = (req_size == 2'b11) ||
                 (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    case (req_size)
      2'b00:   begin req_be = 4'b0001 << req_addr[1:0]; req_wd = {4{req_wdata[7:0]}};  end
      2'b01:   begin req_be = 4'b0011 << req_addr[1:0]; req_wd = {2{req_wdata[15:0]}}; end
      default: begin req_be = 4'b1111;                  req_wd = req_wdata;            end
    endcase
  end

  always_comb begin
    state_n      = state;
    lat_write_n  = lat_write;
    lat_size_n   = lat_size;
    lat_signed_n = lat_signed;
    lat_off_n    = lat_off;
    wait_cnt_n   = wait_cnt;
    req_ready_n  = 1'b0;
    resp_valid_n = 1'b0;
    resp_err_n   = resp_err;
    resp_rdata_n = resp_rdata;
    address_n    = av.address;
    writedata_n  = av.writedata;
    byteenable_n = av.byteenable;
    read_n       = av.read;
    write_n      = av.write;

    case (state)
      IDLE: begin
        req_ready_n = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_n  = 1'b0;
          lat_write_n  = req_write;
          lat_size_n   = req_size;
          lat_signed_n = req_signed;
          lat_off_n    = req_addr[1:0];
          if (misaligned) begin
            // Rejected before any bus activity.
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
            resp_rdata_n = 32'd0;
          end else begin
            state_n      = BUS;
            wait_cnt_n   = 32'd0;
            address_n    = req_addr & 32'hFFFF_FFFC;
            writedata_n  = req_wd;
            byteenable_n = req_be;
            read_n       = ~req_write;
            write_n      = req_write;
          end
        end
      end

      BUS: begin
        if (!av.waitrequest) begin
          state_n      = RESP;
          read_n       = 1'b0;
          write_n      = 1'b0;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b0;
          resp_rdata_n = lat_write ? 32'd0
                                   : extend_load(av.readdata, lat_off, lat_size, lat_signed);
        end else if (TIMEOUT != 0 && wait_cnt + 32'd1 == TIMEOUT) begin
          // This stalled edge is the TIMEOUT-th one: abandon the transfer.
          state_n      = RESP;
          read_n       = 1'b0;
          write_n      = 1'b0;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b1;
          resp_rdata_n = 32'd0;
        end else begin
          wait_cnt_n = wait_cnt + 32'd1;
        end
      end

      RESP: begin
        state_n     = IDLE;
        req_ready_n = 1'b1;
        wait_cnt_n  = 32'd0;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lat_write     <= 1'b0;
      lat_size      <= 2'b00;
      lat_signed    <= 1'b0;
      lat_off       <= 2'b00;
      wait_cnt      <= 32'd0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= 32'd0;
      av.address    <= 32'd0;
      av.writedata  <= 32'd0;
      av.byteenable <= 4'd0;
      av.read       <= 1'b0;
      av.write      <= 1'b0;
    end else begin
      state         <= state_n;
      lat_write     <= lat_write_n;
      lat_size      <= lat_size_n;
      lat_signed    <= lat_signed_n;
      lat_off       <= lat_off_n;
      wait_cnt      <= wait_cnt_n;
      req_ready     <= req_ready_n;
      resp_valid    <= resp_valid_n;
      resp_err      <= resp_err_n;
      resp_rdata    <= resp_rdata_n;
      av.address    <= address_n;
      av.writedata  <= writedata_n;
      av.byteenable <= byteenable_n;
      av.read       <= read_n;
      av.write      <= write_n;
    end
  end

endmodule

// File: tb/tb_mips_avalon_master.sv
// tb/tb_mips_avalon_master.sv - directed scoreboard bench for mips_avalon_master
module tb_mips_avalon_master;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  mips_avalon_master_if av ();

  mips_avalon_master #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .av         (av.master)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          resp_seen = 0;
  logic        prev_rv = 1'b0;

  int          ws_cfg = 0;
  int          ws_cnt = 0;
  logic [31:0] rd_cfg = 32'd0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  logic [31:0] last_addr = 32'd0;
  logic [3:0]  last_be = 4'd0;
  logic [31:0] last_wd = 32'd0;
  logic        both_high = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave model: stalls ws_cfg cycles per transfer, records what the master drove.
  always @(negedge clk) begin
    av.readdata = rd_cfg;
    if (av.read === 1'b1 && av.write === 1'b1) both_high = 1'b1;
    if (av.read === 1'b1 || av.write === 1'b1) begin
      if (av.read === 1'b1) rd_cycles++;
      if (av.write === 1'b1) wr_cycles++;
      last_addr = av.address;
      last_be   = av.byteenable;
      last_wd   = av.writedata;
      av.waitrequest = (ws_cnt < ws_cfg);
      ws_cnt++;
    end else begin
      ws_cnt = 0;
      av.waitrequest = 1'b0;
    end
  end

  // Response monitor: pops the scoreboard on each resp_valid.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid === 1'b1) begin
      resp_seen++;
      chk("resp_one_cycle", {31'd0, prev_rv}, 32'd0);
      chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_latency", cyc - acc_cyc, e.lat);
      end
    end
    prev_rv = (resp_valid === 1'b1);
  end

  task automatic do_req(input bit w, input logic [31:0] a, input logic [1:0] sz, input bit sg,
                        input logic [31:0] wd, input int ws, input logic [31:0] rd,
                        input logic [31:0] exp_rd, input bit exp_err, input int exp_lat,
                        input bit poke);
    int   n;
    int   seen0;
    exp_t e;
    ws_cfg = ws;
    rd_cfg = rd;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    rd_cycles = 0;
    wr_cycles = 0;
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_size   = sz;
    req_signed = sg;
    req_wdata  = wd;
    e.rd = exp_rd;
    e.err = exp_err;
    e.lat = exp_lat;
    sb.push_back(e);
    seen0   = resp_seen;
    acc_cyc = cyc + 1;
    @(negedge clk);
    // Scramble inputs after acceptance; the DUT must not resample them.
    req_valid  = 1'b0;
    req_write  = ~w;
    req_addr   = 32'hDEAD_BEE0;
    req_size   = 2'b11;
    req_signed = ~sg;
    req_wdata  = ~wd;
    if (poke) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_0040;
      req_size  = 2'b10;
      @(negedge clk);
      req_valid = 1'b0;
    end
    n = 0;
    while (resp_seen == seen0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("resp_count", resp_seen - seen0, 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_wdata  = 32'd0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_read", {31'd0, av.read}, 32'd0);
    chk("rst_write", {31'd0, av.write}, 32'd0);
    chk("rst_address", av.address, 32'd0);
    chk("rst_writedata", av.writedata, 32'd0);
    chk("rst_byteenable", {28'd0, av.byteenable}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Word load, 2 waitstates.
    do_req(1'b0, 32'hBFC0_0004, 2'b10, 1'b0, 32'd0, 2, 32'h1122_3344, 32'h1122_3344, 1'b0, 3, 1'b0);
    chk("wl_address", last_addr, 32'hBFC0_0004);
    chk("wl_be", {28'd0, last_be}, 32'hF);
    chk("wl_read_cycles", rd_cycles, 32'd3);
    chk("wl_write_cycles", wr_cycles, 32'd0);

    // Signed and unsigned byte loads from lane 3.
    do_req(1'b0, 32'hBFC0_0003, 2'b00, 1'b1, 32'd0, 0, 32'h80FF_00AA, 32'hFFFF_FF80, 1'b0, 1, 1'b0);
    chk("sb_address", last_addr, 32'hBFC0_0000);
    chk("sb_be", {28'd0, last_be}, 32'h8);
    chk("sb_read_cycles", rd_cycles, 32'd1);
    do_req(1'b0, 32'hBFC0_0003, 2'b00, 1'b0, 32'd0, 0, 32'h80FF_00AA, 32'h0000_0080, 1'b0, 1, 1'b0);

    // Half store to upper lanes, 1 waitstate.
    do_req(1'b1, 32'hBFC0_0002, 2'b01, 1'b0, 32'h0000_BEEF, 1, 32'h1234_5678, 32'd0, 1'b0, 2, 1'b0);
    chk("hs_writedata", last_wd, 32'hBEEF_BEEF);
    chk("hs_be", {28'd0, last_be}, 32'hC);
    chk("hs_write_cycles", wr_cycles, 32'd2);
    chk("hs_read_cycles", rd_cycles, 32'd0);

    // Misaligned word load and illegal size: no bus cycle.
    do_req(1'b0, 32'hBFC0_0001, 2'b10, 1'b0, 32'd0, 0, 32'hFFFF_FFFF, 32'd0, 1'b1, 0, 1'b0);
    chk("mis_read_cycles", rd_cycles, 32'd0);
    do_req(1'b0, 32'hBFC0_0008, 2'b11, 1'b0, 32'd0, 0, 32'hFFFF_FFFF, 32'd0, 1'b1, 0, 1'b0);
    chk("sz11_read_cycles", rd_cycles, 32'd0);
    do_req(1'b1, 32'h0000_0003, 2'b01, 1'b0, 32'h1111_2222, 0, 32'd0, 32'd0, 1'b1, 0, 1'b0);
    chk("mis_write_cycles", wr_cycles, 32'd0);

    // Byte store lane 1, half loads signed.
    do_req(1'b1, 32'h0000_0101, 2'b00, 1'b0, 32'h1234_5678, 0, 32'd0, 32'd0, 1'b0, 1, 1'b0);
    chk("bs_writedata", last_wd, 32'h7878_7878);
    chk("bs_be", {28'd0, last_be}, 32'h2);
    chk("bs_address", last_addr, 32'h0000_0100);
    do_req(1'b0, 32'h0000_0002, 2'b01, 1'b1, 32'd0, 0, 32'h8001_1234, 32'hFFFF_8001, 1'b0, 1, 1'b0);
    chk("hl_be", {28'd0, last_be}, 32'hC);
    do_req(1'b0, 32'h0000_0000, 2'b01, 1'b1, 32'd0, 0, 32'h8001_F234, 32'hFFFF_F234, 1'b0, 1, 1'b0);
    chk("hl0_be", {28'd0, last_be}, 32'h3);
    do_req(1'b0, 32'h0000_0004, 2'b10, 1'b1, 32'd0, 0, 32'h8000_0001, 32'h8000_0001, 1'b0, 1, 1'b0);

    // Word store, 3 waitstates (just under the timeout).
    do_req(1'b1, 32'h0000_0010, 2'b10, 1'b0, 32'hCAFE_F00D, 3, 32'd0, 32'd0, 1'b0, 4, 1'b0);
    chk("ws_writedata", last_wd, 32'hCAFE_F00D);
    chk("ws_be", {28'd0, last_be}, 32'hF);
    chk("ws_write_cycles", wr_cycles, 32'd4);

    // Timeout: slave never releases waitrequest.
    do_req(1'b0, 32'h0000_0020, 2'b10, 1'b0, 32'd0, 1000, 32'hA5A5_A5A5, 32'd0, 1'b1, 4, 1'b0);
    chk("to_read_cycles", rd_cycles, 32'd4);

    // Request attempted while busy must be ignored.
    do_req(1'b0, 32'h0000_0030, 2'b10, 1'b0, 32'd0, 3, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, 4, 1'b1);
    chk("busy_address", last_addr, 32'h0000_0030);
    repeat (6) @(negedge clk);
    chk("busy_no_extra_resp", sb.size(), 32'd0);

    // Reset during a stalled BUS cycle aborts with no response.
    begin
      int seen0;
      ws_cfg = 1000;
      rd_cfg = 32'h0BAD_0BAD;
      seen0 = resp_seen;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_0044;
      req_size  = 2'b10;
      @(negedge clk);
      req_valid = 1'b0;
      chk("ab_read_high", {31'd0, av.read}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("ab_read_low", {31'd0, av.read}, 32'd0);
      chk("ab_ready_in_rst", {31'd0, req_ready}, 32'd0);
      chk("ab_address_clr", av.address, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ab_ready_after", {31'd0, req_ready}, 32'd1);
      repeat (6) @(negedge clk);
      chk("ab_no_resp", resp_seen - seen0, 32'd0);
    end

    chk("never_both_strobes", {31'd0, both_high}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
